// File: rtl/stack_unit.sv
// Descending LIFO stack with registered top-of-stack output, full/empty FSM and error flag.
// Define STACK_UNIT_ERR_STICKY_EN to hold err high after the first illegal operation until reset.
module stack_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_push,
  input  logic                  ctrl_pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [DEPTH_LOG2:0]   sp,
  output logic                  empty,
  output logic                  full,
  output logic                  err
);

  localparam int SP_W  = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [SP_W-1:0] SP_EMPTY = SP_W'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [SP_W-1:0]         sp_nxt, sp_dec, sp_inc;
  logic [DATA_WIDTH-1:0]   dout_nxt;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic                    illegal;

  assign sp_dec = sp - 1'b1;
  assign sp_inc = sp + 1'b1;

  // Operation decode: push+pop on a non-empty stack replaces the top word in place.
  always_comb begin
    sp_nxt   = sp;
    dout_nxt = data_out;
    wr_en    = 1'b0;
    wr_idx   = sp_dec[DEPTH_LOG2-1:0];
    illegal  = 1'b0;
    if (ctrl_push && ctrl_pop && !empty) begin
      wr_en    = 1'b1;
      wr_idx   = sp[DEPTH_LOG2-1:0];
      dout_nxt = data_in;
    end else if (ctrl_push) begin
      if (full) begin
        illegal = 1'b1;
      end else begin
        wr_en    = 1'b1;
        sp_nxt   = sp_dec;
        dout_nxt = data_in;
      end
    end else if (ctrl_pop) begin
      if (empty) begin
        illegal = 1'b1;
      end else begin
        sp_nxt   = sp_inc;
        // Popping the last word exposes nothing: the new top is reported as zero.
        dout_nxt = (sp_inc != SP_EMPTY) ? mem[sp_inc[DEPTH_LOG2-1:0]] : '0;
      end
    end
  end

  // Storage is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && rst) mem[wr_idx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= SP_EMPTY;
      data_out <= '0;
    end else begin
      sp       <= sp_nxt;
      data_out <= dout_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
`ifdef STACK_UNIT_ERR_STICKY_EN
      err <= err | illegal;
`else
      err <= illegal;
`endif
    end
  end

  // FSM: state register / next-state / output decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_PARTIAL;
    if (sp_nxt == SP_EMPTY)   state_nxt = S_EMPTY;
    else if (sp_nxt == '0)    state_nxt = S_FULL;
  end

  always_comb begin
    empty = (state == S_EMPTY);
    full  = (state == S_FULL);
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit (DATA_WIDTH=8, DEPTH_LOG2=3) with hand-computed expectations.
module tb_stack_unit;

  logic       clk;
  logic       rst;
  logic       ctrl_push;
  logic       ctrl_pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [3:0] sp;
  logic       empty;
  logic       full;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef STACK_UNIT_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  stack_unit #(.DATA_WIDTH(8), .DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_push (ctrl_push),
    .ctrl_pop  (ctrl_pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one operation across a rising edge; outputs are sampled 1 time unit after it.
  task automatic step(input logic push, input logic pop, input logic [7:0] din);
    ctrl_push = push;
    ctrl_pop  = pop;
    data_in   = din;
    @(posedge clk);
    #1;
    ctrl_push = 1'b0;
    ctrl_pop  = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_sp, input logic [7:0] e_do,
                         input logic e_empty, input logic e_full, input logic e_err);
    chk({tag, ".sp"},    32'(sp),       32'(e_sp));
    chk({tag, ".dout"},  32'(data_out), 32'(e_do));
    chk({tag, ".empty"}, 32'(empty),    32'(e_empty));
    chk({tag, ".full"},  32'(full),     32'(e_full));
    chk({tag, ".err"},   32'(err),      32'(e_err));
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    ctrl_push = 1'b0;
    ctrl_pop  = 1'b0;
    data_in   = 8'h00;
    #22;
    chk_all("reset", 4'd8, 8'h00, 1'b1, 1'b0, 1'b0);
    release_reset();

    // Push three words, then pop them all back off.
    step(1, 0, 8'h11); chk_all("push11", 4'd7, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1, 0, 8'h22); chk_all("push22", 4'd6, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1, 0, 8'h33); chk_all("push33", 4'd5, 8'h33, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h00); chk_all("pop1",   4'd6, 8'h22, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h00); chk_all("pop2",   4'd7, 8'h11, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h00); chk_all("pop3",   4'd8, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill to capacity, then overflow.
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i));
    chk_all("fill8", 4'd0, 8'h08, 1'b0, 1'b1, 1'b0);
    step(1, 0, 8'hFF); chk_all("ovf",      4'd0, 8'h08, 1'b0, 1'b1, 1'b1);
    step(0, 0, 8'h00); chk_all("ovf_idle", 4'd0, 8'h08, 1'b0, 1'b1, STICKY);
    step(0, 1, 8'h00); chk_all("pop_full", 4'd1, 8'h07, 1'b0, 1'b0, STICKY);

    async_reset();
    chk_all("rst_full", 4'd8, 8'h00, 1'b1, 1'b0, 1'b0);
    release_reset();

    // Underflow, then push+pop on an empty stack behaves as a push.
    step(0, 1, 8'h00); chk_all("udf",      4'd8, 8'h00, 1'b1, 1'b0, 1'b1);
    step(0, 0, 8'h00); chk_all("udf_idle", 4'd8, 8'h00, 1'b1, 1'b0, STICKY);
    step(1, 1, 8'h5A); chk_all("pp_empty", 4'd7, 8'h5A, 1'b0, 1'b0, STICKY);
    step(0, 1, 8'h00); chk_all("pp_drain", 4'd8, 8'h00, 1'b1, 1'b0, STICKY);

    async_reset();
    release_reset();

    // Replace top of a two-word stack.
    step(1, 0, 8'h10);
    step(1, 0, 8'h20); chk_all("two",     4'd6, 8'h20, 1'b0, 1'b0, 1'b0);
    step(1, 1, 8'h77); chk_all("replace", 4'd6, 8'h77, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h00); chk_all("pop_rep", 4'd7, 8'h10, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h00); chk_all("pop_rep2", 4'd8, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset between edges with four words stacked.
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    step(1, 0, 8'hA3);
    step(1, 0, 8'hA4); chk_all("four", 4'd4, 8'hA4, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_all("rst_mid", 4'd8, 8'h00, 1'b1, 1'b0, 1'b0);
    release_reset();
    step(1, 0, 8'hB5); chk_all("post_rst_push", 4'd7, 8'hB5, 1'b0, 1'b0, 1'b0);
    step(0, 1, 8'h00); chk_all("post_rst_pop",  4'd8, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
